fta_mem_responder: RTL

Single-port FTA bus target that answers `fta_cmd_request128_t` transactions from a bus initiator, such as the rf80386 core, with `fta_cmd_response128_t` responses. Storage is an internal 128-bit-wide line RAM. Every accepted transaction gets exactly one response (ack, rty or err) at a fixed, parameterised latency, with the request's tid echoed back. It sits on the system bus as a boot/scratch memory or test target, behind whatever fabric routes initiator requests.

---
 rtl/fta_mem_responder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fta_mem_responder.sv
// FTA bus target backed by a 128-bit line RAM. Every window hit gets exactly one
// ack/rty/err response LATENCY cycles after the request, with tid and adr echoed.

package fta_bus_pkg;

  typedef logic [7:0] fta_tranid_t;

  typedef struct packed {
    logic          cyc;
    logic          stb;
    logic          we;
    logic [15:0]   sel;
    logic [31:0]   adr;
    logic [127:0]  dat;
    fta_tranid_t   tid;
  } fta_cmd_request128_t;

  typedef struct packed {
    logic          stall;
    logic          next;
    logic          ack;
    logic          rty;
    logic          err;
    fta_tranid_t   tid;
    logic [31:0]   adr;
    logic [127:0]  dat;
  } fta_cmd_response128_t;

endpackage

module fta_mem_responder
  import fta_bus_pkg::*;
#(
  parameter logic [31:0] BASE    = 32'hFFFF0000,
  parameter logic [31:0] MASK    = 32'h0000FFFF,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 hold_i,
  input  fta_cmd_request128_t  ftas_req,
  output fta_cmd_response128_t ftas_resp
);

  localparam int LW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    RSP_ACK = 2'd0,
    RSP_RTY = 2'd1,
    RSP_ERR = 2'd2
  } rsp_e;

  typedef struct packed {
    logic        vld;
    rsp_e        typ;
    logic        rd;
    fta_tranid_t tid;
    logic [31:0] adr;
  } stage_t;

  logic [127:0] mem     [DEPTH];
  stage_t       stg     [LATENCY];
  logic [127:0] stg_dat [LATENCY];

  logic          req_vld;
  logic          win_hit;
  logic          oob;
  logic [31:0]   line_full;
  logic [LW-1:0] line;
  rsp_e          req_typ;
  logic          wr_en;
  stage_t        last;

  // Classification happens entirely in the request cycle; hold wins over range errors.
  always_comb begin
    req_vld   = ftas_req.cyc & ftas_req.stb;
    win_hit   = (ftas_req.adr & ~MASK) == BASE;
    line_full = (ftas_req.adr & MASK) >> 4;
    oob       = line_full >= 32'(DEPTH);
    line      = ftas_req.adr[4 +: LW];
    req_typ   = RSP_ACK;
    if (hold_i)
      req_typ = RSP_RTY;
    else if (oob)
      req_typ = RSP_ERR;
    wr_en = req_vld & win_hit & (req_typ == RSP_ACK) & ftas_req.we;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < 16; k++) begin
        if (ftas_req.sel[k])
          mem[line][k*8 +: 8] <= ftas_req.dat[k*8 +: 8];
      end
    end
  end

  // Read data rides alongside the control pipeline without reset; it is masked at the output.
  always_ff @(posedge clk_i) begin
    stg_dat[0] <= mem[line];
    for (int i = 1; i < LATENCY; i++)
      stg_dat[i] <= stg_dat[i-1];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < LATENCY; i++)
        stg[i] <= '0;
    end else begin
      stg[0] <= '{vld: req_vld & win_hit,
                  typ: req_typ,
                  rd:  ~ftas_req.we & (req_typ == RSP_ACK),
                  tid: ftas_req.tid,
                  adr: ftas_req.adr};
      for (int i = 1; i < LATENCY; i++)
        stg[i] <= stg[i-1];
    end
  end

  always_comb begin
    last      = stg[LATENCY-1];
    ftas_resp = '0;
    if (last.vld) begin
      ftas_resp.ack = last.typ == RSP_ACK;
      ftas_resp.rty = last.typ == RSP_RTY;
      ftas_resp.err = last.typ == RSP_ERR;
      ftas_resp.tid = last.tid;
      ftas_resp.adr = last.adr;
      if (last.rd)
        ftas_resp.dat = stg_dat[LATENCY-1];
    end
  end

endmodule
